dmem_lsu: RTL and testbench

- Load/store unit sitting directly upstream of the 64-bit byte-addressed data memory, on the CPU's MEM stage side.
- Accepts one RISC-V-style load/store request at a time and drives the memory's address, read/write and bidirectional data bus.
- The memory always reads and writes 8 bytes starting at addr. Sub-doubleword stores therefore use a read-modify-write sequence. Load results are sign- or zero-extended before return.

---
 rtl/dmem_lsu_pkg.sv | 20 ++
 rtl/dmem_lsu_align.sv | 36 +++
 rtl/dmem_lsu.sv | 117 +++++++++++
 tb/tb_dmem_lsu.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// funct3 width/sign codes follow the RISC-V load/store encoding.
package dmem_lsu_pkg;
   localparam int DATA_W = 64;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } state_t;
endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational store-merge and load-extend for an 8-byte memory word.
// Purely combinational; shared with any future cache fill/write path.
module dmem_lsu_align
   import dmem_lsu_pkg::*;
(
   input  logic [DATA_W-1:0] rbuf,
   input  logic [DATA_W-1:0] wdata,
   input  logic [2:0]        funct3,
   output logic [DATA_W-1:0] merged,
   output logic [DATA_W-1:0] extended
);

   always_comb begin
      merged = wdata;
      case (funct3)
         F3_B:    merged = {rbuf[63:8],  wdata[7:0]};
         F3_H:    merged = {rbuf[63:16], wdata[15:0]};
         F3_W:    merged = {rbuf[63:32], wdata[31:0]};
         default: merged = wdata;
      endcase
   end

   always_comb begin
      extended = rbuf;
      case (funct3)
         F3_B:    extended = {{56{rbuf[7]}},  rbuf[7:0]};
         F3_H:    extended = {{48{rbuf[15]}}, rbuf[15:0]};
         F3_W:    extended = {{32{rbuf[31]}}, rbuf[31:0]};
         F3_BU:   extended = {56'd0, rbuf[7:0]};
         F3_HU:   extended = {48'd0, rbuf[15:0]};
         F3_WU:   extended = {32'd0, rbuf[31:0]};
         default: extended = rbuf;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of the 8-byte-wide data memory: one request at a time,
// read-modify-write for narrow stores, sign/zero extension for loads.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int DM_SIZE = 9192
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [DATA_W-1:0] mem_addr,
   output logic              mem_rw,
   inout  wire  [DATA_W-1:0] mem_data
);

   localparam logic [DATA_W-1:0] ADDR_MAX = DATA_W'(DM_SIZE - 8);

   state_t            state_q, state_d;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [DATA_W-1:0] addr_q, wdata_q, rbuf_q, rdata_q;
   logic              err_q;
   logic              accept, req_bad;
   logic [DATA_W-1:0] align_rbuf, merged, extended;

   assign accept  = req_valid && (state_q == ST_IDLE);
   assign req_bad = (req_funct3 == 3'b111) || (req_we && req_funct3[2]) || (req_addr > ADDR_MAX);

   // In RD the extender sees the live bus so the load result is ready at the closing edge.
   assign align_rbuf = (state_q == ST_RD) ? mem_data : rbuf_q;

   dmem_lsu_align u_align (
      .rbuf     (align_rbuf),
      .wdata    (wdata_q),
      .funct3   (f3_q),
      .merged   (merged),
      .extended (extended)
   );

   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      mem_rw     = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_bad)                            state_d = ST_RESP;
               else if (req_we && req_funct3 == F3_D)  state_d = ST_WR;
               else                                    state_d = ST_RD;
            end
         end
         ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
         ST_WR: begin
            mem_rw  = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rbuf_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            wdata_q <= req_wdata;
            // Rejected requests never reach the memory, so mem_addr keeps its old value.
            if (!req_bad) addr_q <= req_addr;
            if (req_bad) begin
               err_q   <= 1'b1;
               rdata_q <= '0;
            end
         end
         if (state_q == ST_RD) begin
            rbuf_q <= mem_data;
            if (!we_q) begin
               err_q   <= 1'b0;
               rdata_q <= extended;
            end
         end
         if (state_q == ST_WR) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
         end
      end
   end

   assign mem_addr   = addr_q;
   assign mem_data   = mem_rw ? merged : 'z;
   assign resp_err   = err_q;
   assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a byte-array data memory model on the shared bus.
module tb_dmem_lsu;
   localparam int DM_SIZE = 9192;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid, resp_err;
   logic [63:0] resp_rdata, mem_addr;
   logic        mem_rw;
   wire  [63:0] mem_data;

   logic [7:0]  mem [0:DM_SIZE-1];
   logic [63:0] rd_word;
   int          wr_cnt = 0;
   int          total = 0;
   int          bad = 0;

   dmem_lsu #(.DM_SIZE(DM_SIZE)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .resp_rdata (resp_rdata),
      .mem_addr   (mem_addr),
      .mem_rw     (mem_rw),
      .mem_data   (mem_data)
   );

   always #5 clk = ~clk;

   // Memory model: combinational 8-byte read, write committed on negedge.
   always_comb begin
      rd_word = '0;
      if (mem_addr <= 64'(DM_SIZE - 8))
         for (int i = 0; i < 8; i++) rd_word[8*i +: 8] = mem[int'(mem_addr) + i];
   end

   assign mem_data = mem_rw ? 64'bz : rd_word;

   always @(negedge clk) begin
      if (mem_rw) begin
         wr_cnt <= wr_cnt + 1;
         if (mem_addr <= 64'(DM_SIZE - 8))
            for (int i = 0; i < 8; i++) mem[int'(mem_addr) + i] <= mem_data[8*i +: 8];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input int exp_lat, input logic exp_err,
                         input logic [63:0] exp_rd, input int exp_wr);
      int w0;
      int lat;
      bit got;
      @(negedge clk);
      check({tag, "_rdy"}, 64'(req_ready), 64'd1);
      w0         = wr_cnt;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = '0;
      req_wdata  = '0;
      lat = 0;
      got = 1'b0;
      for (int i = 1; i <= 8 && !got; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            got = 1'b1;
            lat = i;
         end
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      if (got) begin
         check({tag, "_err"}, 64'(resp_err), 64'(exp_err));
         check({tag, "_rdata"}, resp_rdata, exp_rd);
         @(negedge clk);
         check({tag, "_pulse"}, 64'(resp_valid), 64'd0);
      end
      #1;
      check({tag, "_wrcyc"}, 64'(wr_cnt - w0), 64'(exp_wr));
   endtask

   initial begin
      int w0;
      for (int i = 0; i < DM_SIZE; i++) mem[i] = 8'h00;
      // Bytes 0x10..0x17 = 0x0C3C3EAAF00FCC33, LSB first.
      mem[16] = 8'h33; mem[17] = 8'hCC; mem[18] = 8'h0F; mem[19] = 8'hF0;
      mem[20] = 8'hAA; mem[21] = 8'h3E; mem[22] = 8'h3C; mem[23] = 8'h0C;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready",  64'(req_ready),  64'd1);
      check("rst_vld",    64'(resp_valid), 64'd0);
      check("rst_err",    64'(resp_err),   64'd0);
      check("rst_rdata",  resp_rdata,      64'd0);
      check("rst_rw",     64'(mem_rw),     64'd0);
      check("rst_addr",   mem_addr,        64'd0);

      // Loads
      do_req("lb10",  0, 3'b000, 64'h10, 0, 2, 0, 64'h0000000000000033, 0);
      do_req("lb12",  0, 3'b000, 64'h12, 0, 2, 0, 64'h000000000000000F, 0);
      do_req("lh11",  0, 3'b001, 64'h11, 0, 2, 0, 64'h0000000000000FCC, 0);
      do_req("lw12",  0, 3'b010, 64'h12, 0, 2, 0, 64'h000000003EAAF00F, 0);
      do_req("lb13",  0, 3'b000, 64'h13, 0, 2, 0, 64'hFFFFFFFFFFFFFFF0, 0);
      do_req("lbu13", 0, 3'b100, 64'h13, 0, 2, 0, 64'h00000000000000F0, 0);
      do_req("lh13",  0, 3'b001, 64'h13, 0, 2, 0, 64'hFFFFFFFFFFFFAAF0, 0);
      do_req("lhu13", 0, 3'b101, 64'h13, 0, 2, 0, 64'h000000000000AAF0, 0);
      do_req("lwu10", 0, 3'b110, 64'h10, 0, 2, 0, 64'h00000000F00FCC33, 0);
      do_req("lw10",  0, 3'b010, 64'h10, 0, 2, 0, 64'hFFFFFFFFF00FCC33, 0);
      do_req("ld10",  0, 3'b011, 64'h10, 0, 2, 0, 64'h0C3C3EAAF00FCC33, 0);

      // Narrow stores via read-modify-write
      do_req("sb10",  1, 3'b000, 64'h10, 64'hFFFFFFFFFFFFFF55, 3, 0, 64'd0, 1);
      do_req("ld10b", 0, 3'b011, 64'h10, 0, 2, 0, 64'h0C3C3EAAF00FCC55, 0);
      do_req("ld0c",  0, 3'b011, 64'h0C, 0, 2, 0, 64'hF00FCC5500000000, 0);
      do_req("sh14",  1, 3'b001, 64'h14, 64'hAAAAAAAAAAAA1234, 3, 0, 64'd0, 1);
      do_req("sw16",  1, 3'b010, 64'h16, 64'h55555555DEADBEEF, 3, 0, 64'd0, 1);
      do_req("ld10c", 0, 3'b011, 64'h10, 0, 2, 0, 64'hBEEF1234F00FCC55, 0);
      do_req("ld18",  0, 3'b011, 64'h18, 0, 2, 0, 64'h000000000000DEAD, 0);

      // Full doubleword store skips the read
      do_req("sd20",  1, 3'b011, 64'h20, 64'h0123456789ABCDEF, 2, 0, 64'd0, 1);
      do_req("ld20",  0, 3'b011, 64'h20, 0, 2, 0, 64'h0123456789ABCDEF, 0);

      // Address boundary and illegal codes
      do_req("sdtop", 1, 3'b011, 64'(DM_SIZE - 8), 64'hA5A5A5A55A5A5A5A, 2, 0, 64'd0, 1);
      do_req("ldtop", 0, 3'b011, 64'(DM_SIZE - 8), 0, 2, 0, 64'hA5A5A5A55A5A5A5A, 0);
      do_req("ldovr", 0, 3'b011, 64'(DM_SIZE - 7), 0, 1, 1, 64'd0, 0);
      do_req("ldbig", 0, 3'b000, 64'hFFFFFFFFFFFFFFF8, 0, 1, 1, 64'd0, 0);
      do_req("ld111", 0, 3'b111, 64'h10, 0, 1, 1, 64'd0, 0);
      do_req("st100", 1, 3'b100, 64'h10, 64'h77, 1, 1, 64'd0, 0);
      do_req("sdovr", 1, 3'b011, 64'(DM_SIZE - 7), 64'h1, 1, 1, 64'd0, 0);
      do_req("ldok",  0, 3'b011, 64'h20, 0, 2, 0, 64'h0123456789ABCDEF, 0);

      // Reset while a byte store is in its read phase drops it without writing
      @(negedge clk);
      w0         = wr_cnt;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 64'h10;
      req_wdata  = 64'h77;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mrst_ready", 64'(req_ready),  64'd1);
      check("mrst_vld",   64'(resp_valid), 64'd0);
      check("mrst_rw",    64'(mem_rw),     64'd0);
      check("mrst_wrcyc", 64'(wr_cnt - w0), 64'd0);
      do_req("mrst_ld", 0, 3'b011, 64'h10, 0, 2, 0, 64'hBEEF1234F00FCC55, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
